// File: rtl/gate_array_seq.sv
// -----------------------------------------------------------------------------
// gate_array_seq
//
// Time-multiplexed WIDTH-bit bitwise two-input function unit. Only LANES gate
// lanes are evaluated per clock; the WIDTH-bit result is assembled slice by
// slice in an output register. This trades latency for gate-package count.
//
// Functions (OP): 00 OR, 01 AND, 10 XOR, 11 NOR.
//
// Optional feature, macro GATE_ARRAY_SEQ_ACC_EN:
//   Adds the ACC input. With ACC=1 at accept, the current Y (the previous
//   result) replaces B as the second operand, and Y is not cleared, so
//   results can be chained (e.g. a sticky OR across operations).
//   With the macro undefined there is no ACC port and B always comes from B.
//
// Handshake (valid/ready):
//   A request is accepted on a rising CLK edge where IN_VALID && IN_READY.
//   OP, A, B (and ACC) are sampled on that edge only and may change freely
//   afterwards. A result is consumed on a rising edge where
//   OUT_VALID && OUT_READY. IN_VALID while IN_READY=0 is ignored, never
//   queued; OUT_READY while OUT_VALID=0 is ignored.
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   IN_VALID   request valid
//   IN_READY   unit is idle and accepts a request this cycle
//   OP[1:0]    function select, sampled at accept
//   A, B       WIDTH-bit operands, sampled at accept
//   ACC        (GATE_ARRAY_SEQ_ACC_EN only) accumulate select
//   OUT_VALID  Y holds a complete result
//   OUT_READY  consumer takes the result
//   Y          result register
//   BUSY       slices are being evaluated
//   SLICE      index of the slice being evaluated
//
// The FSM state is fully visible on the outputs: IN_READY marks IDLE, BUSY
// marks BUSY and OUT_VALID marks DONE (exactly one is high out of reset).
// -----------------------------------------------------------------------------
module gate_array_seq #(
    parameter int  WIDTH  = 12,
    parameter int  LANES  = 4,
    localparam int NSLICE = (WIDTH + LANES - 1) / LANES,
    localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef GATE_ARRAY_SEQ_ACC_EN
    input  logic             ACC,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             BUSY,
    output logic [SW-1:0]    SLICE
);

    localparam logic [SW-1:0] LAST_SLICE = SW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last_slice;

    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [1:0]       op_lat;
    logic [SW-1:0]    slice_q;
    logic [WIDTH-1:0] y_q;

    logic [WIDTH-1:0] f_all;
    logic [WIDTH-1:0] y_slice;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        last_slice = (slice_q == LAST_SLICE);
        IN_READY   = 1'b0;
        BUSY       = 1'b0;
        OUT_VALID  = 1'b0;
        case (state_q)
            S_IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    accept  = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                BUSY = 1'b1;
                if (last_slice) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Gate function over the full width; only the current slice's bits
    // are ever committed to Y.
    // ------------------------------------------------------------------
    always_comb begin
        f_all = '0;
        case (op_lat)
            2'b00:   f_all = a_lat | b_lat;
            2'b01:   f_all = a_lat & b_lat;
            2'b10:   f_all = a_lat ^ b_lat;
            default: f_all = ~(a_lat | b_lat);
        endcase
    end

    // Select bits by slice membership (bit i belongs to slice i/LANES)
    // rather than by computed index, so a partial last slice never reaches
    // past WIDTH-1: lanes beyond WIDTH simply have no bit to write.
    always_comb begin
        y_slice = y_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(slice_q) == (i / LANES)) begin
                y_slice[i] = f_all[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand latches, slice counter and result register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_lat   <= '0;
            b_lat   <= '0;
            op_lat  <= '0;
            slice_q <= '0;
            y_q     <= '0;
        end else if (accept) begin
            a_lat   <= A;
            op_lat  <= OP;
            slice_q <= '0;
`ifdef GATE_ARRAY_SEQ_ACC_EN
            // Accumulate: previous result becomes the second operand and
            // stays in Y; each slice then overwrites only its own bits.
            if (ACC) begin
                b_lat <= y_q;
            end else begin
                b_lat <= B;
                y_q   <= '0;
            end
`else
            b_lat   <= B;
            y_q     <= '0;
`endif
        end else if (state_q == S_BUSY) begin
            y_q <= y_slice;
            if (last_slice) begin
                slice_q <= '0;
            end else begin
                slice_q <= slice_q + SW'(1);
            end
        end
    end

    assign Y     = y_q;
    assign SLICE = slice_q;

endmodule

// File: tb/tb_gate_array_seq.sv
// -----------------------------------------------------------------------------
// tb_gate_array_seq
//
// Directed bench for gate_array_seq. Two instances share the stimulus:
//   u_dut   WIDTH=12, LANES=4 (NSLICE=3, full slices)
//   u_dut10 WIDTH=10, LANES=4 (NSLICE=3, partial last slice)
// Both have the same latency, so they run in lockstep; u_dut10 sees the low
// 10 bits of A and B. Expected results are hand-computed constants pushed
// into exp_q at accept and popped when the result is checked.
// -----------------------------------------------------------------------------
module tb_gate_array_seq;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic        in_valid;
    logic [1:0]  op;
    logic [11:0] a;
    logic [11:0] b;
    logic        out_ready;
    logic        acc;

    logic        in_ready;
    logic        out_valid;
    logic [11:0] y;
    logic        busy;
    logic [1:0]  slice;

    logic        in_ready10;
    logic        out_valid10;
    logic [9:0]  y10;
    logic        busy10;
    logic [1:0]  slice10;

    gate_array_seq #(.WIDTH(12), .LANES(4)) u_dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OP        (op),
        .A         (a),
        .B         (b),
`ifdef GATE_ARRAY_SEQ_ACC_EN
        .ACC       (acc),
`endif
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .Y         (y),
        .BUSY      (busy),
        .SLICE     (slice)
    );

    gate_array_seq #(.WIDTH(10), .LANES(4)) u_dut10 (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready10),
        .OP        (op),
        .A         (a[9:0]),
        .B         (b[9:0]),
`ifdef GATE_ARRAY_SEQ_ACC_EN
        .ACC       (acc),
`endif
        .OUT_VALID (out_valid10),
        .OUT_READY (out_ready),
        .Y         (y10),
        .BUSY      (busy10),
        .SLICE     (slice10)
    );

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    logic [9:0]  exp10_q[$];
    int          n_total;
    int          n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble the operands to show
    // they no longer matter.
    task automatic accept(input logic [1:0] f, input logic [11:0] av, input logic [11:0] bv,
                          input logic accv, input logic [11:0] e12, input logic [9:0] e10);
        op       = f;
        a        = av;
        b        = bv;
        acc      = accv;
        in_valid = 1'b1;
        exp_q.push_back(e12);
        exp10_q.push_back(e10);
        tick();
        in_valid = 1'b0;
        a        = 12'($urandom_range(0, 4095));
        b        = 12'($urandom_range(0, 4095));
        op       = 2'($urandom_range(0, 3));
        acc      = 1'b0;
    endtask

    // Wait (bounded) for OUT_VALID, check latency and result, then optionally
    // consume it. 'done' is the number of edges already taken since accept.
    task automatic wait_done(input string tag, input int done, input logic release_it);
        int          n;
        logic [11:0] e12;
        logic [9:0]  e10;
        n = done;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        e12 = exp_q.pop_front();
        e10 = exp10_q.pop_front();
        chk({tag, "_latency"}, 32'(n), 32'd3);
        chk({tag, "_y12"}, 32'(y), 32'(e12));
        chk({tag, "_y10"}, 32'(y10), 32'(e10));
        chk({tag, "_valid10"}, 32'(out_valid10), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        if (release_it) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
            chk({tag, "_held_y"}, 32'(y), 32'(e12));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [11:0] held;
        n_total   = 0;
        n_pass    = 0;
        in_valid  = 1'b0;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        acc       = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_slice", 32'(slice), 32'd0);

        // Basic OR with slice-by-slice visibility: 0xA50 | 0x00F = 0xA5F
        accept(2'b00, 12'hA50, 12'h00F, 1'b0, 12'hA5F, 10'h25F);
        chk("or_busy0", 32'(busy), 32'd1);
        chk("or_in_ready0", 32'(in_ready), 32'd0);
        chk("or_slice0", 32'(slice), 32'd0);
        chk("or_y_cleared", 32'(y), 32'd0);
        tick();
        chk("or_slice1", 32'(slice), 32'd1);
        chk("or_y_part1", 32'(y), 32'h00F);
        chk("or_valid_early", 32'(out_valid), 32'd0);
        tick();
        chk("or_slice2", 32'(slice), 32'd2);
        chk("or_y_part2", 32'(y), 32'h05F);
        wait_done("or", 2, 1'b1);
        chk("or_slice_reset", 32'(slice), 32'd0);

        // Function sweep on 0xF0C, 0x3A5
        accept(2'b01, 12'hF0C, 12'h3A5, 1'b0, 12'h304, 10'h304);
        wait_done("and", 0, 1'b1);
        accept(2'b10, 12'hF0C, 12'h3A5, 1'b0, 12'hCA9, 10'h0A9);
        wait_done("xor", 0, 1'b1);
        accept(2'b11, 12'hF0C, 12'h3A5, 1'b0, 12'h052, 10'h052);
        wait_done("nor", 0, 1'b1);

        // Partial last slice on the 10-bit instance
        accept(2'b00, 12'h3FF, 12'h000, 1'b0, 12'h3FF, 10'h3FF);
        wait_done("partial", 0, 1'b1);

        // Backpressure: result held, new request ignored
        accept(2'b00, 12'h123, 12'h456, 1'b0, 12'h577, 10'h177);
        wait_done("bp", 0, 1'b0);
        held     = y;
        in_valid = 1'b1;
        a        = 12'h111;
        b        = 12'h000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_y_stable", 32'(y), 32'h577);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle", 32'(in_ready), 32'd1);
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        chk("bp_y_retained", 32'(y), 32'(held));
        tick();
        chk("bp_still_idle", 32'(in_ready), 32'd1);
        chk("bp_y_retained2", 32'(y), 32'h577);

        // Reset in the middle of an operation
        accept(2'b00, 12'hFFF, 12'h000, 1'b0, 12'hFFF, 10'h3FF);
        tick();
        chk("mid_slice1", 32'(slice), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp10_q.delete();
        chk("mid_rst_y", 32'(y), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_slice", 32'(slice), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        accept(2'b00, 12'h001, 12'h002, 1'b0, 12'h003, 10'h003);
        wait_done("after_rst", 0, 1'b1);

`ifdef GATE_ARRAY_SEQ_ACC_EN
        // Chained accumulation
        accept(2'b00, 12'h001, 12'h000, 1'b0, 12'h001, 10'h001);
        wait_done("acc1", 0, 1'b1);
        accept(2'b00, 12'h800, 12'h0F0, 1'b1, 12'h801, 10'h001);
        wait_done("acc2", 0, 1'b1);
        accept(2'b10, 12'h801, 12'h0F0, 1'b1, 12'h000, 10'h000);
        wait_done("acc3", 0, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
